// File: rtl/fsab_rr_arbiter.sv
// Round-robin arbiter merging per-channel beat FIFOs into one credited stream.
// Define FSAB_ARB_PRIO0_EN to give channel 0 strict priority over the rest.
module fsab_rr_arbiter #(
  parameter  int DEVICES     = 4,
  parameter  int PAYLOAD_W   = 128,
  parameter  int DEPTH       = 8,
  parameter  int OUT_CREDITS = 4,
  localparam int DW = (DEVICES > 1) ? $clog2(DEVICES) : 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(OUT_CREDITS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DEVICES-1:0]           in_valid,
  input  logic [DEVICES-1:0]           in_last,
  input  logic [DEVICES*PAYLOAD_W-1:0] in_payload,
  output logic [DEVICES-1:0]           in_credit,
  output logic                         out_valid,
  output logic                         out_last,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [DW-1:0]                out_device,
  input  logic                         out_credit,
  output logic                         err
);

  typedef enum logic {IDLE, BURST} state_e;
  typedef logic [PAYLOAD_W:0] entry_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  entry_t        mem_q  [DEVICES][DEPTH];
  entry_t        mem_d  [DEVICES][DEPTH];
  logic [AW-1:0] wptr_q [DEVICES];
  logic [AW-1:0] wptr_d [DEVICES];
  logic [AW-1:0] rptr_q [DEVICES];
  logic [AW-1:0] rptr_d [DEVICES];
  logic [AW:0]   cnt_q  [DEVICES];
  logic [AW:0]   cnt_d  [DEVICES];
  logic [AW:0]   lcnt_q [DEVICES];
  logic [AW:0]   lcnt_d [DEVICES];

  logic [DW-1:0] rr_q, rr_d;
  logic [DW-1:0] dev_q, dev_d;
  logic [CW-1:0] cred_q, cred_d;
  logic          err_q, err_d;

  logic [DEVICES-1:0] elig, cand, pop, wr_ok;
  logic [DW-1:0]      win, idx;
  logic               found, grant, burst;
  logic               ovf, cred_ovf;
  entry_t             head;

  always_comb begin : arb
    for (int i = 0; i < DEVICES; i++) begin
      elig[i] = (lcnt_q[i] != '0);
    end
    cand  = elig;
    found = 1'b0;
    win   = '0;
    idx   = '0;
`ifdef FSAB_ARB_PRIO0_EN
    cand[0] = 1'b0;
    found   = elig[0];
`endif
    for (int k = 0; k < DEVICES; k++) begin
      idx = DW'((int'(rr_q) + k) % DEVICES);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin : ctrl
    state_d  = state_q;
    dev_d    = dev_q;
    rr_d     = rr_q;
    cred_d   = cred_q;
    cred_ovf = 1'b0;
    head     = mem_q[dev_q][rptr_q[dev_q]];
    burst    = (state_q == BURST) && !rst;
    grant    = (state_q == IDLE) && found && (cred_q != '0);
    pop      = '0;
    pop[dev_q] = burst;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = BURST;
          dev_d   = win;
`ifdef FSAB_ARB_PRIO0_EN
          if (win != '0)
`endif
          rr_d = (win == DW'(DEVICES - 1)) ? '0 : win + 1'b1;
        end
      end
      BURST: begin
        if (burst && head[PAYLOAD_W]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // a grant and a returned credit in the same cycle cancel out
    if (grant && !out_credit) begin
      cred_d = cred_q - 1'b1;
    end else if (out_credit && !grant) begin
      if (cred_q == CW'(OUT_CREDITS)) cred_ovf = 1'b1;
      else cred_d = cred_q + 1'b1;
    end
  end

  always_comb begin : fifo
    mem_d = mem_q;
    wr_ok = '0;
    ovf   = 1'b0;
    for (int i = 0; i < DEVICES; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      wr_ok[i]  = in_valid[i] && ((cnt_q[i] != FULL) || pop[i]);
      if (in_valid[i] && !wr_ok[i]) ovf = 1'b1;
      if (wr_ok[i]) begin
        mem_d[i][wptr_q[i]] =
          {in_last[i], in_payload[i*PAYLOAD_W +: PAYLOAD_W]};
        wptr_d[i] = wptr_q[i] + 1'b1;
      end
      if (pop[i]) rptr_d[i] = rptr_q[i] + 1'b1;
      cnt_d[i]  = cnt_q[i]
                + {{AW{1'b0}}, wr_ok[i]}
                - {{AW{1'b0}}, pop[i]};
      lcnt_d[i] = lcnt_q[i]
                + {{AW{1'b0}}, wr_ok[i] & in_last[i]}
                - {{AW{1'b0}}, pop[i] & head[PAYLOAD_W]};
    end
  end

  assign err_d = err_q | ovf | cred_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      dev_q   <= '0;
      cred_q  <= CW'(OUT_CREDITS);
      err_q   <= 1'b0;
      for (int i = 0; i < DEVICES; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
        lcnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      dev_q   <= dev_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
      for (int i = 0; i < DEVICES; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
        lcnt_q[i] <= lcnt_d[i];
      end
    end
  end

  // storage needs no reset: the pointers and counts define validity
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid   = burst;
  assign out_last    = burst & head[PAYLOAD_W];
  assign out_payload = head[PAYLOAD_W-1:0];
  assign out_device  = dev_q;
  assign in_credit   = pop;
  assign err         = err_q;

endmodule

// File: tb/tb_fsab_rr_arbiter.sv
// Scoreboard bench for fsab_rr_arbiter: grant order, timing, credits, errors.
// Build with FSAB_ARB_PRIO0_EN defined to check the channel-0 priority mode.
module tb_fsab_rr_arbiter;

  localparam int D  = 4;
  localparam int PW = 16;
  localparam int DP = 8;
  localparam int OC = 4;

  typedef struct packed {
    logic [1:0]    dev;
    logic          last;
    logic [PW-1:0] pl;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [D-1:0]  in_valid, in_last, in_credit;
  logic [D*PW-1:0] in_payload;
  logic          out_valid, out_last, out_credit, err;
  logic [PW-1:0] out_payload;
  logic [1:0]    out_device;

  beat_t sb[$];
  int    total  = 0;
  int    passed = 0;
  int    beats  = 0;

  always #5 clk = ~clk;

  fsab_rr_arbiter #(
    .DEVICES(D), .PAYLOAD_W(PW), .DEPTH(DP), .OUT_CREDITS(OC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_last(in_last), .in_payload(in_payload),
    .in_credit(in_credit),
    .out_valid(out_valid), .out_last(out_last),
    .out_payload(out_payload), .out_device(out_device),
    .out_credit(out_credit), .err(err)
  );

  function automatic beat_t mk(input int dev, input logic last,
                               input logic [PW-1:0] pl);
    beat_t b;
    b.dev  = 2'(dev);
    b.last = last;
    b.pl   = pl;
    return b;
  endfunction

  // scoreboard: every emitted beat is compared with the predicted next beat
  always @(negedge clk) begin
    beat_t e;
    logic [D-1:0] cr;
    if (!rst) begin
      if (out_valid) begin
        beats++;
        total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: got dev=%0d pl=%h, want no beat",
                   out_device, out_payload);
        end else begin
          e = sb.pop_front();
          if ({out_device, out_last, out_payload} !== e)
            $display("FAIL sb_beat: got dev=%0d last=%0b pl=%h want dev=%0d last=%0b pl=%h",
                     out_device, out_last, out_payload, e.dev, e.last, e.pl);
          else passed++;
        end
      end
      cr = out_valid ? (4'b0001 << out_device) : 4'b0000;
      if (out_valid || in_credit != '0) begin
        total++;
        if (in_credit !== cr)
          $display("FAIL in_credit: got %b want %b", in_credit, cr);
        else passed++;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    in_valid   = '0;
    in_last    = '0;
    in_payload = '0;
    out_credit = 1'b0;
  endtask

  task automatic put(input int ch, input logic last, input logic [PW-1:0] pl);
    in_valid[ch]            = 1'b1;
    in_last[ch]             = last;
    in_payload[ch*PW +: PW] = pl;
  endtask

  task automatic do_reset;
    idle_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    total++; if (out_valid !== 1'b0)
      $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_last !== 1'b0)
      $display("FAIL rst_out_last: got %b want 0", out_last); else passed++;
    total++; if (out_device !== 2'd0)
      $display("FAIL rst_out_device: got %0d want 0", out_device); else passed++;
    total++; if (in_credit !== 4'b0)
      $display("FAIL rst_in_credit: got %b want 0", in_credit); else passed++;
    total++; if (err !== 1'b0)
      $display("FAIL rst_err: got %b want 0", err); else passed++;
    total++; if (dut.cred_q !== 3'(OC))
      $display("FAIL rst_credits: got %0d want %0d", dut.cred_q, OC); else passed++;
  endtask

  task automatic test_single;
    logic [5:0] vexp;
    vexp = 6'b011100;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(); idle_in();
      put(2, k == 2, 16'h2000 + 16'(k));
      sb.push_back(mk(2, k == 2, 16'h2000 + 16'(k)));
    end
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin step(); idle_in(); end
      @(negedge clk);
      total++; if (out_valid !== vexp[c])
        $display("FAIL single_valid_c%0d: got %b want %b", c, out_valid, vexp[c]);
      else passed++;
      if (vexp[c]) begin
        total++; if (out_device !== 2'd2)
          $display("FAIL single_dev_c%0d: got %0d want 2", c, out_device);
        else passed++;
      end
    end
    total++; if (dut.cred_q !== 3'(OC - 1))
      $display("FAIL single_credits: got %0d want %0d", dut.cred_q, OC - 1);
    else passed++;
    total++; if (sb.size() != 0)
      $display("FAIL single_drain: got %0d left want 0", sb.size()); else passed++;
  endtask

  task automatic test_rr_order;
    logic [7:0] vexp;
    int devs [3];
    int n;
    vexp = 8'b01010100;
    devs = '{0, 1, 3};
    n = 0;
    do_reset();
    step(); idle_in();
    put(0, 1'b1, 16'h0A00);
    put(1, 1'b1, 16'h1A01);
    put(3, 1'b1, 16'h3A03);
    sb.push_back(mk(0, 1'b1, 16'h0A00));
    sb.push_back(mk(1, 1'b1, 16'h1A01));
    sb.push_back(mk(3, 1'b1, 16'h3A03));
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin step(); idle_in(); end
      @(negedge clk);
      total++; if (out_valid !== vexp[c])
        $display("FAIL rr_valid_c%0d: got %b want %b", c, out_valid, vexp[c]);
      else passed++;
      if (vexp[c]) begin
        total++; if (out_device !== 2'(devs[n]))
          $display("FAIL rr_dev_c%0d: got %0d want %0d", c, out_device, devs[n]);
        else passed++;
        n++;
      end
    end
    total++; if (dut.rr_q !== 2'd0)
      $display("FAIL rr_ptr_end: got %0d want 0", dut.rr_q); else passed++;
  endtask

  task automatic test_credits;
    do_reset();
    beats = 0;
    step(); idle_in();
    for (int ch = 0; ch < D; ch++) begin
      put(ch, 1'b1, 16'hC000 + 16'(ch));
      sb.push_back(mk(ch, 1'b1, 16'hC000 + 16'(ch)));
    end
    step(); idle_in();
    put(1, 1'b1, 16'hC101);
    put(2, 1'b1, 16'hC102);
    sb.push_back(mk(1, 1'b1, 16'hC101));
    repeat (20) begin step(); idle_in(); end
    @(negedge clk);
    total++; if (beats != OC)
      $display("FAIL credits_stall: got %0d beats want %0d", beats, OC); else passed++;
    total++; if (dut.cred_q !== 3'd0)
      $display("FAIL credits_zero: got %0d want 0", dut.cred_q); else passed++;
    step(); out_credit = 1'b1;
    step(); out_credit = 1'b0;
    repeat (8) step();
    @(negedge clk);
    total++; if (beats != OC + 1)
      $display("FAIL credits_resume: got %0d beats want %0d", beats, OC + 1);
    else passed++;
    total++; if (sb.size() != 0)
      $display("FAIL credits_drain: got %0d left want 0", sb.size()); else passed++;
  endtask

  task automatic test_credit_grant;
    do_reset();
    step(); idle_in();
    put(2, 1'b1, 16'hB002);
    sb.push_back(mk(2, 1'b1, 16'hB002));
    step(); idle_in();
    out_credit = 1'b1;
    step(); idle_in();
    @(negedge clk);
    total++; if (dut.cred_q !== 3'(OC))
      $display("FAIL cred_grant_same: got %0d want %0d", dut.cred_q, OC); else passed++;
    total++; if (err !== 1'b0)
      $display("FAIL cred_grant_err: got %b want 0", err); else passed++;
    repeat (3) step();
  endtask

  task automatic test_credit_overflow;
    do_reset();
    step(); out_credit = 1'b1;
    step(); out_credit = 1'b0;
    @(negedge clk);
    total++; if (err !== 1'b1)
      $display("FAIL cred_ovf_err: got %b want 1", err); else passed++;
    total++; if (dut.cred_q !== 3'(OC))
      $display("FAIL cred_ovf_hold: got %0d want %0d", dut.cred_q, OC); else passed++;
  endtask

  task automatic test_overflow;
    do_reset();
    beats = 0;
    for (int k = 0; k < DP + 1; k++) begin
      step(); idle_in();
      put(1, 1'b0, 16'h1100 + 16'(k));
    end
    @(negedge clk);
    total++; if (err !== 1'b0)
      $display("FAIL ovf_full_ok: got %b want 0", err); else passed++;
    step(); idle_in();
    @(negedge clk);
    total++; if (err !== 1'b1)
      $display("FAIL ovf_set: got %b want 1", err); else passed++;
    repeat (5) step();
    @(negedge clk);
    total++; if (err !== 1'b1)
      $display("FAIL ovf_sticky: got %b want 1", err); else passed++;
    total++; if (dut.cnt_q[1] !== 4'(DP))
      $display("FAIL ovf_count: got %0d want %0d", dut.cnt_q[1], DP); else passed++;
    total++; if (beats != 0)
      $display("FAIL ovf_no_out: got %0d beats want 0", beats); else passed++;
    do_reset();
    @(negedge clk);
    total++; if (err !== 1'b0)
      $display("FAIL ovf_cleared: got %b want 0", err); else passed++;
  endtask

  task automatic test_full_pass;
    do_reset();
    beats = 0;
    for (int k = 0; k < DP; k++) begin
      step(); idle_in();
      put(1, k == DP - 1, 16'hF100 + 16'(k));
      sb.push_back(mk(1, k == DP - 1, 16'hF100 + 16'(k)));
    end
    step(); idle_in();
    step(); idle_in();
    put(1, 1'b1, 16'hF1FF);
    sb.push_back(mk(1, 1'b1, 16'hF1FF));
    repeat (14) begin step(); idle_in(); end
    @(negedge clk);
    total++; if (err !== 1'b0)
      $display("FAIL full_pass_err: got %b want 0", err); else passed++;
    total++; if (beats != DP + 1)
      $display("FAIL full_pass_beats: got %0d want %0d", beats, DP + 1); else passed++;
    total++; if (sb.size() != 0)
      $display("FAIL full_pass_drain: got %0d left want 0", sb.size()); else passed++;
  endtask

  task automatic test_back_to_back;
    logic lastseen;
    do_reset();
    beats = 0;
    lastseen = 1'b0;
`ifdef FSAB_ARB_PRIO0_EN
    for (int k = 0; k < 3; k++) sb.push_back(mk(0, 1'b1, 16'(k)));
    for (int k = 0; k < 3; k++) sb.push_back(mk(1, 1'b1, 16'h0100 + 16'(k)));
`else
    for (int k = 0; k < 3; k++) begin
      sb.push_back(mk(0, 1'b1, 16'(k)));
      sb.push_back(mk(1, 1'b1, 16'h0100 + 16'(k)));
    end
`endif
    for (int c = 0; c < 28; c++) begin
      step(); idle_in();
      out_credit = lastseen;
      if (c < 3) begin
        put(0, 1'b1, 16'(c));
        put(1, 1'b1, 16'h0100 + 16'(c));
      end
      @(negedge clk);
      lastseen = out_valid && out_last;
    end
    total++; if (beats != 6)
      $display("FAIL b2b_beats: got %0d want 6", beats); else passed++;
    total++; if (sb.size() != 0)
      $display("FAIL b2b_drain: got %0d left want 0", sb.size()); else passed++;
    total++; if (dut.cred_q !== 3'(OC))
      $display("FAIL b2b_credits: got %0d want %0d", dut.cred_q, OC); else passed++;
    total++; if (err !== 1'b0)
      $display("FAIL b2b_err: got %b want 0", err); else passed++;
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    beats = 0;
    for (int k = 0; k < 4; k++) begin
      step(); idle_in();
      put(3, k == 3, 16'h3300 + 16'(k));
    end
    sb.push_back(mk(3, 1'b0, 16'h3300));
    step(); idle_in();
    step(); idle_in();
    @(negedge clk);
    total++; if (out_valid !== 1'b1)
      $display("FAIL mid_first_beat: got %b want 1", out_valid); else passed++;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0)
      $display("FAIL mid_valid: got %b want 0", out_valid); else passed++;
    total++; if (in_credit !== 4'b0)
      $display("FAIL mid_in_credit: got %b want 0", in_credit); else passed++;
    total++; if (dut.cred_q !== 3'(OC))
      $display("FAIL mid_credits: got %0d want %0d", dut.cred_q, OC); else passed++;
    total++; if (dut.cnt_q[3] !== 4'd0 || dut.lcnt_q[3] !== 4'd0)
      $display("FAIL mid_fifo: got cnt=%0d lcnt=%0d want 0/0",
               dut.cnt_q[3], dut.lcnt_q[3]);
    else passed++;
    repeat (5) step();
    @(negedge clk);
    total++; if (beats != 1)
      $display("FAIL mid_no_more: got %0d beats want 1", beats); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    test_reset();
    test_single();
    test_rr_order();
    test_credits();
    test_credit_grant();
    test_credit_overflow();
    test_overflow();
    test_full_pass();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
